// File: rtl/pio_debounce_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : pio_debounce_pkg                                             |
// | Purpose : Shared constants for the debounced PIO with interrupt:       |
// |           register word addresses, default ID word, default debounce   |
// |           counter width and the power-up initialisation states.        |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package pio_debounce_pkg;

   // Avalon-MM word addresses
   localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
   localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
   localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
   localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
   localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
   localparam logic [2:0] ADDR_FALL_EN  = 3'd5;
   localparam logic [2:0] ADDR_DB_LIMIT = 3'd6;
   localparam logic [2:0] ADDR_ID       = 3'd7;

   localparam logic [31:0] ID_VALUE_DEFAULT     = 32'h5049_4F32;
   localparam int          DB_CNT_WIDTH_DEFAULT = 20;

   // Power-up sequence: two cycles to fill the synchronisers, one cycle
   // to load the stable flops from valid synchronised pins, then run.
   typedef enum logic [1:0] {
      INIT_FILL0 = 2'd0,
      INIT_FILL1 = 2'd1,
      INIT_LOAD  = 2'd2,
      INIT_RUN   = 2'd3
   } init_state_e;

endpackage
`default_nettype wire

// File: rtl/pio_debounce_chan.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : pio_debounce_chan                                            |
// | Purpose : One input channel: 2-flop synchroniser, debounce counter,    |
// |           stable flop and single-cycle rise/fall pulses that appear    |
// |           in the cycle after the stable value changes.                 |
// | Ports   : clk, rst_n      clock, async active-low reset                |
// |           pin             asynchronous input pin                       |
// |           init            0 = load stable from sync, no edges          |
// |           db_limit        debounce length in cycles (0 acts as 1)      |
// |           cnt_clr         clears the debounce counter                  |
// |           stable          debounced level                              |
// |           rise_pulse      stable went 0->1 on the previous edge        |
// |           fall_pulse      stable went 1->0 on the previous edge        |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module pio_debounce_chan
   import pio_debounce_pkg::*;
#(
   parameter int DB_CNT_WIDTH = DB_CNT_WIDTH_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    pin,
   input  logic                    init,
   input  logic [DB_CNT_WIDTH-1:0] db_limit,
   input  logic                    cnt_clr,
   output logic                    stable,
   output logic                    rise_pulse,
   output logic                    fall_pulse
);

   logic [1:0]              sync_ff;
   logic                    sync;
   logic                    stable_d;
   logic [DB_CNT_WIDTH-1:0] cnt;
   logic [DB_CNT_WIDTH-1:0] last_cnt;

   assign sync = sync_ff[1];

   // Terminal count is max(db_limit,1)-1, so a zero limit still needs
   // exactly one mismatching cycle.
   assign last_cnt = (db_limit == '0) ? '0 : (db_limit - DB_CNT_WIDTH'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_ff <= 2'b00;
      end else begin
         sync_ff <= {sync_ff[0], pin};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable   <= 1'b0;
         stable_d <= 1'b0;
         cnt      <= '0;
      end else if (!init) begin
         // Both copies track sync so no edge can be seen when init rises.
         stable   <= sync;
         stable_d <= sync;
         cnt      <= '0;
      end else begin
         stable_d <= stable;
         if (cnt_clr || (sync == stable)) begin
            cnt <= '0;
         end else if (cnt == last_cnt) begin
            stable <= sync;
            cnt    <= '0;
         end else begin
            cnt <= cnt + DB_CNT_WIDTH'(1);
         end
      end
   end

   assign rise_pulse =  stable & ~stable_d;
   assign fall_pulse = ~stable &  stable_d;

endmodule
`default_nettype wire

// File: rtl/pio_debounce_irq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : pio_debounce_irq                                             |
// | Purpose : Avalon-MM PIO with IN_WIDTH debounced inputs, OUT_WIDTH      |
// |           registered outputs, rise/fall edge capture and a maskable    |
// |           level interrupt.                                             |
// | Ports   : clk_clk          clock                                       |
// |           reset_reset_n    async active-low reset                      |
// |           avs_address/read/write/writedata  Avalon-MM slave inputs     |
// |           avs_readdata     read data, latency 1                        |
// |           in_port_export   asynchronous input pins                     |
// |           out_port_export  registered output bits                      |
// |           irq_irq          |(EDGE_CAP & IRQ_MASK)                      |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module pio_debounce_irq
   import pio_debounce_pkg::*;
#(
   parameter int          IN_WIDTH     = 4,
   parameter int          OUT_WIDTH    = 3,
   parameter int          DB_CNT_WIDTH = DB_CNT_WIDTH_DEFAULT,
   parameter logic [31:0] DB_DEFAULT   = 32'd50000,
   parameter logic [31:0] OUT_RESET    = 32'd0,
   parameter logic [31:0] ID_VALUE     = ID_VALUE_DEFAULT
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   input  logic [2:0]           avs_address,
   input  logic                 avs_read,
   input  logic                 avs_write,
   input  logic [31:0]          avs_writedata,
   output logic [31:0]          avs_readdata,
   input  logic [IN_WIDTH-1:0]  in_port_export,
   output logic [OUT_WIDTH-1:0] out_port_export,
   output logic                 irq_irq
);

   init_state_e             state;
   init_state_e             state_next;
   logic                    init;

   logic [IN_WIDTH-1:0]     irq_mask;
   logic [IN_WIDTH-1:0]     edge_cap;
   logic [IN_WIDTH-1:0]     rise_en;
   logic [IN_WIDTH-1:0]     fall_en;
   logic [DB_CNT_WIDTH-1:0] db_limit;

   logic [IN_WIDTH-1:0]     stable;
   logic [IN_WIDTH-1:0]     rise;
   logic [IN_WIDTH-1:0]     fall;
   logic [IN_WIDTH-1:0]     edge_set;
   logic [IN_WIDTH-1:0]     edge_w1c;
   logic [31:0]             rd_mux;

   logic wr_data_out;
   logic wr_irq_mask;
   logic wr_edge_cap;
   logic wr_rise_en;
   logic wr_fall_en;
   logic wr_db_limit;
   logic unused_wdata;

   // Bits above the implemented widths are intentionally ignored.
   assign unused_wdata = ^avs_writedata;

   // ---------------------------------------------------------------- init
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state <= INIT_FILL0;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         INIT_FILL0: state_next = INIT_FILL1;
         INIT_FILL1: state_next = INIT_LOAD;
         INIT_LOAD:  state_next = INIT_RUN;
         INIT_RUN:   state_next = INIT_RUN;
         default:    state_next = INIT_FILL0;
      endcase
   end

   assign init = (state == INIT_RUN);

   // ------------------------------------------------------------ channels
   generate
      for (genvar i = 0; i < IN_WIDTH; i++) begin : g_chan
         pio_debounce_chan #(
            .DB_CNT_WIDTH (DB_CNT_WIDTH)
         ) u_chan (
            .clk        (clk_clk),
            .rst_n      (reset_reset_n),
            .pin        (in_port_export[i]),
            .init       (init),
            .db_limit   (db_limit),
            .cnt_clr    (wr_db_limit),
            .stable     (stable[i]),
            .rise_pulse (rise[i]),
            .fall_pulse (fall[i])
         );
      end
   endgenerate

   // ------------------------------------------------------- write decode
   assign wr_data_out = avs_write && (avs_address == ADDR_DATA_OUT);
   assign wr_irq_mask = avs_write && (avs_address == ADDR_IRQ_MASK);
   assign wr_edge_cap = avs_write && (avs_address == ADDR_EDGE_CAP);
   assign wr_rise_en  = avs_write && (avs_address == ADDR_RISE_EN);
   assign wr_fall_en  = avs_write && (avs_address == ADDR_FALL_EN);
   assign wr_db_limit = avs_write && (avs_address == ADDR_DB_LIMIT);

   assign edge_set = (rise & rise_en) | (fall & fall_en);
   assign edge_w1c = wr_edge_cap ? avs_writedata[IN_WIDTH-1:0] : '0;

   // -------------------------------------------------------- register file
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         out_port_export <= OUT_RESET[OUT_WIDTH-1:0];
         irq_mask        <= '0;
         edge_cap        <= '0;
         rise_en         <= '1;
         fall_en         <= '0;
         db_limit        <= DB_DEFAULT[DB_CNT_WIDTH-1:0];
      end else begin
         if (wr_data_out) out_port_export <= avs_writedata[OUT_WIDTH-1:0];
         if (wr_irq_mask) irq_mask        <= avs_writedata[IN_WIDTH-1:0];
         if (wr_rise_en)  rise_en         <= avs_writedata[IN_WIDTH-1:0];
         if (wr_fall_en)  fall_en         <= avs_writedata[IN_WIDTH-1:0];
         if (wr_db_limit) db_limit        <= avs_writedata[DB_CNT_WIDTH-1:0];
         // Set is OR-ed after the clear so a coincident edge is never lost.
         edge_cap <= (edge_cap & ~edge_w1c) | edge_set;
      end
   end

   // ---------------------------------------------------------- read path
   always_comb begin
      rd_mux = '0;
      case (avs_address)
         ADDR_DATA_IN:  rd_mux[IN_WIDTH-1:0]     = stable;
         ADDR_DATA_OUT: rd_mux[OUT_WIDTH-1:0]    = out_port_export;
         ADDR_IRQ_MASK: rd_mux[IN_WIDTH-1:0]     = irq_mask;
         ADDR_EDGE_CAP: rd_mux[IN_WIDTH-1:0]     = edge_cap;
         ADDR_RISE_EN:  rd_mux[IN_WIDTH-1:0]     = rise_en;
         ADDR_FALL_EN:  rd_mux[IN_WIDTH-1:0]     = fall_en;
         ADDR_DB_LIMIT: rd_mux[DB_CNT_WIDTH-1:0] = db_limit;
         ADDR_ID:       rd_mux                   = ID_VALUE;
         default:       rd_mux                   = '0;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         avs_readdata <= '0;
      end else if (avs_read) begin
         avs_readdata <= rd_mux;
      end
   end

   assign irq_irq = |(edge_cap & irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_pio_debounce_irq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_pio_debounce_irq                                          |
// | Purpose : Directed self-checking bench for pio_debounce_irq. Read      |
// |           expectations go into a queue when the read is issued and are |
// |           popped when avs_readdata is valid one cycle later.           |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_pio_debounce_irq;

   logic        clk;
   logic        rst_n;
   logic [2:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [3:0]  pins;
   logic [2:0]  out_port;
   logic        irq;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   pio_debounce_irq #(
      .IN_WIDTH     (4),
      .OUT_WIDTH    (3),
      .DB_CNT_WIDTH (20),
      .DB_DEFAULT   (32'd50000),
      .OUT_RESET    (32'd0),
      .ID_VALUE     (32'h5049_4F32)
   ) dut (
      .clk_clk         (clk),
      .reset_reset_n   (rst_n),
      .avs_address     (address),
      .avs_read        (read),
      .avs_write       (write),
      .avs_writedata   (writedata),
      .avs_readdata    (readdata),
      .in_port_export  (pins),
      .out_port_export (out_port),
      .irq_irq         (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address   = a;
      writedata = d;
      write     = 1'b1;
      tick(1);
      write     = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
      address = a;
      read    = 1'b1;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      tick(1);
      read    = 1'b0;
      chk(tag_q.pop_front(), readdata, exp_q.pop_front());
   endtask

   initial begin
      rst_n     = 1'b0;
      address   = 3'd0;
      read      = 1'b0;
      write     = 1'b0;
      writedata = 32'd0;
      pins      = 4'b0101;

      // Reset state
      tick(2);
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_out_port", 32'(out_port), 32'h0);

      // Release with buttons held: init loads them, no edge captured
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("init_irq", 32'(irq), 32'h0);
      end
      rd(3'd0, 32'h5, "init_data_in");
      rd(3'd3, 32'h0, "init_edge_cap");
      tick(5);
      rd(3'd3, 32'h0, "init_edge_cap_late");
      chk("init_irq_late", 32'(irq), 32'h0);

      // Debounce of a held 0->1 on channel 0
      wr(3'd6, 32'd4);
      wr(3'd2, 32'h1);
      pins = 4'b0100;
      tick(10);
      rd(3'd0, 32'h4, "fall0_data_in");
      rd(3'd3, 32'h0, "fall0_not_captured");
      pins = 4'b0101;
      tick(5);
      chk("rise0_irq_early", 32'(irq), 32'h0);
      rd(3'd0, 32'h4, "rise0_data_in_before");
      chk("rise0_irq_not_yet", 32'(irq), 32'h0);
      rd(3'd0, 32'h5, "rise0_data_in_after");
      chk("rise0_irq", 32'(irq), 32'h1);
      rd(3'd3, 32'h1, "rise0_edge_cap");
      chk("rise0_irq_with_cap", 32'(irq), 32'h1);
      wr(3'd3, 32'h1);
      chk("w1c_irq", 32'(irq), 32'h0);
      rd(3'd3, 32'h0, "w1c_edge_cap");

      // Glitch rejection on channel 1
      pins = 4'b0111;
      tick(3);
      pins = 4'b0101;
      tick(10);
      rd(3'd0, 32'h5, "glitch3_data_in");
      rd(3'd3, 32'h0, "glitch3_edge_cap");
      chk("glitch3_irq", 32'(irq), 32'h0);
      pins = 4'b0111;
      tick(4);
      pins = 4'b0101;
      tick(12);
      rd(3'd3, 32'h2, "pulse4_edge_cap");
      chk("pulse4_irq_masked", 32'(irq), 32'h0);
      rd(3'd0, 32'h5, "pulse4_data_in_back");
      wr(3'd3, 32'h2);

      // Falling edge on channel 2 with a coincident W1C
      wr(3'd5, 32'h4);
      wr(3'd4, 32'h0);
      pins = 4'b0001;
      tick(6);
      wr(3'd3, 32'h4);
      rd(3'd3, 32'h4, "fall2_set_wins");
      chk("fall2_irq_masked", 32'(irq), 32'h0);
      wr(3'd3, 32'h4);
      rd(3'd3, 32'h0, "fall2_cleared");
      rd(3'd0, 32'h1, "fall2_data_in");

      // Output port, readbacks and ID
      wr(3'd1, 32'hFFFF_FFFF);
      chk("out_port_all", 32'(out_port), 32'h7);
      rd(3'd1, 32'h7, "data_out_rb");
      rd(3'd7, 32'h5049_4F32, "id");
      rd(3'd2, 32'h1, "irq_mask_rb");
      rd(3'd4, 32'h0, "rise_en_rb");
      rd(3'd5, 32'h4, "fall_en_rb");
      rd(3'd6, 32'h4, "db_limit_rb");
      wr(3'd0, 32'hF);
      wr(3'd7, 32'h0);
      rd(3'd0, 32'h1, "data_in_ro");
      rd(3'd7, 32'h5049_4F32, "id_ro");
      // Simultaneous read and write returns the old value
      address   = 3'd1;
      writedata = 32'h2;
      read      = 1'b1;
      write     = 1'b1;
      exp_q.push_back(32'h7);
      tag_q.push_back("rw_same_old");
      tick(1);
      read  = 1'b0;
      write = 1'b0;
      chk(tag_q.pop_front(), readdata, exp_q.pop_front());
      chk("rw_same_out_port", 32'(out_port), 32'h2);

      // DB_LIMIT=0: one-cycle follow
      wr(3'd6, 32'd0);
      pins = 4'b1001;
      tick(2);
      rd(3'd0, 32'h1, "bypass_before");
      rd(3'd0, 32'h9, "bypass_after");
      rd(3'd3, 32'h0, "bypass_no_rise_cap");

      // Capture an edge, start a long count, then reset mid-count
      wr(3'd4, 32'hF);
      wr(3'd2, 32'hF);
      pins = 4'b1011;
      tick(4);
      chk("pre_rst_irq", 32'(irq), 32'h1);
      rd(3'd3, 32'h2, "pre_rst_edge_cap");
      wr(3'd6, 32'd100);
      pins = 4'b1111;
      tick(10);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_irq", 32'(irq), 32'h0);
      chk("mid_rst_out_port", 32'(out_port), 32'h0);
      chk("mid_rst_readdata", readdata, 32'h0);
      tick(2);
      rst_n = 1'b1;
      tick(3);
      rd(3'd0, 32'hF, "re_init_data_in");
      rd(3'd3, 32'h0, "re_init_edge_cap");
      rd(3'd2, 32'h0, "re_init_irq_mask");
      rd(3'd4, 32'hF, "re_init_rise_en");
      rd(3'd5, 32'h0, "re_init_fall_en");
      rd(3'd6, 32'd50000, "re_init_db_limit");
      rd(3'd1, 32'h0, "re_init_data_out");
      tick(10);
      rd(3'd3, 32'h0, "re_init_edge_cap_late");
      chk("re_init_irq", 32'(irq), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
